output_block_vc: RTL and testbench

Per-output-port stage that sits directly downstream of the crossbar fed by the input blocks. It does three things:
- registers the granted flit onto the link;
- keeps the downstream per-VC credit counters;
- tracks the ownership state of each downstream VC.

Its outputs feed back, router-wide, into the input blocks' route computation and VC allocation, as the `ovc_credits_count_r` and `out_vc_free` inputs.

---
 rtl/router_pkg.sv | 32 +++
 rtl/output_block_vc_ovc_tracker.sv | 82 ++++++++
 rtl/output_block_vc.sv | 60 ++++++
 tb/tb_output_block_vc.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Router-wide types and sizing shared by the output block and its per-VC trackers.
package router_pkg;

   localparam int NUM_VCS          = 2;
   localparam int VC_ID_BITS       = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;
   localparam int CREDITS_PER_VC   = 4;
   localparam int CREDIT_CTR_WIDTH = $clog2(CREDITS_PER_VC + 1);
   localparam int FLIT_DATA_WIDTH  = 16;

   localparam logic [CREDIT_CTR_WIDTH-1:0] CREDITS_FULL = CREDIT_CTR_WIDTH'(CREDITS_PER_VC);

   typedef enum logic [2:0] {N, E, S, W, L} dir_t;

   typedef enum logic [2:0] {I, H, B, T, HT} ftype_t;

   typedef struct packed {
      ftype_t                     ftype;
      logic [VC_ID_BITS-1:0]      fvcid;
      logic [FLIT_DATA_WIDTH-1:0] data;
   } channel_t;

   typedef enum logic [1:0] {FREE, BUSY, DRAIN} ovc_state_t;

   function automatic logic isHeadFlit(input ftype_t f);
      return (f == H) || (f == HT);
   endfunction

   function automatic logic isTailFlit(input ftype_t f);
      return (f == T) || (f == HT);
   endfunction

endpackage

// File: rtl/output_block_vc_ovc_tracker.sv
// One downstream VC: saturating credit counter plus FREE/BUSY/DRAIN ownership FSM.
// Illegal events are reported in simulation and leave the FSM state untouched.
module ovc_tracker
   import router_pkg::*;
#(
   parameter dir_t LOCAL_PORT = N,
   parameter int   VC_INDEX   = 0
) (
   input  logic                        clk,
   input  logic                        arst_n,
   input  logic                        send,
   input  logic                        tail,
   input  logic                        head,
   input  logic                        credit,
   input  logic                        alloc,
   output logic [CREDIT_CTR_WIDTH-1:0] count_r,
   output logic                        free_r
);

   ovc_state_t                  state_q, state_d;
   logic [CREDIT_CTR_WIDTH-1:0] count_q, count_d;
   logic                        free_q;
   logic                        underflow, overflow;
   logic                        badAlloc, badSend, badHead;

   // A send and a returned credit in the same cycle cancel out.
   always_comb begin
      count_d   = count_q;
      underflow = 1'b0;
      overflow  = 1'b0;
      if (send && !credit) begin
         if (count_q == '0) underflow = 1'b1;
         else               count_d   = count_q - 1'b1;
      end else if (credit && !send) begin
         if (count_q == CREDITS_FULL) overflow = 1'b1;
         else                         count_d  = count_q + 1'b1;
      end
   end

   always_comb begin
      state_d  = state_q;
      badAlloc = alloc && (state_q != FREE);
      badSend  = send && (state_q == FREE);
      badHead  = send && head && (state_q == DRAIN);
      if (!(badAlloc || badSend || badHead)) begin
         case (state_q)
            FREE:    if (alloc)                    state_d = BUSY;
            BUSY:    if (send && tail)             state_d = DRAIN;
            DRAIN:   if (count_d == CREDITS_FULL)  state_d = FREE;
            default:                               state_d = FREE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!arst_n) begin
         state_q <= FREE;
         count_q <= CREDITS_FULL;
         free_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         free_q  <= (state_d == FREE);
      end
   end

   assign count_r = count_q;
   assign free_r  = free_q;

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (arst_n) begin
         if (underflow) $warning("[ovc_tracker port %0d vc%0d] credit underflow", LOCAL_PORT, VC_INDEX);
         if (overflow)  $warning("[ovc_tracker port %0d vc%0d] credit overflow", LOCAL_PORT, VC_INDEX);
         if (badAlloc)  $warning("[ovc_tracker port %0d vc%0d] allocation of a non-free VC", LOCAL_PORT, VC_INDEX);
         if (badSend)   $warning("[ovc_tracker port %0d vc%0d] flit sent on a free VC", LOCAL_PORT, VC_INDEX);
         if (badHead)   $warning("[ovc_tracker port %0d vc%0d] head flit on a draining VC", LOCAL_PORT, VC_INDEX);
      end
   end
`endif

endmodule

// File: rtl/output_block_vc.sv
// Output port stage: drives the link and tracks downstream VC credits and ownership.
// Build option OB_OUTFLIT_REG_EN registers outflit; otherwise outflit passes straight through.
module output_block_vc
   import router_pkg::*;
#(
   parameter dir_t LOCAL_PORT = N
) (
   input  logic                                     clk,
   input  logic                                     arst_n,
   input  channel_t                                 xbar_flit,
   input  logic                                     credit_valid,
   input  logic [VC_ID_BITS-1:0]                    credit_vcid,
   input  logic                                     alloc_valid,
   input  logic [VC_ID_BITS-1:0]                    alloc_vcid,
   output channel_t                                 outflit,
   output logic [NUM_VCS-1:0][CREDIT_CTR_WIDTH-1:0] credits_count_r,
   output logic [NUM_VCS-1:0]                       vc_free_r
);

   logic flitValid, flitHead, flitTail;

   assign flitValid = (xbar_flit.ftype != I);
   assign flitHead  = isHeadFlit(xbar_flit.ftype);
   assign flitTail  = isTailFlit(xbar_flit.ftype);

   // Trackers watch xbar_flit directly so their timing is the same in both builds.
   for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
      ovc_tracker #(
         .LOCAL_PORT (LOCAL_PORT),
         .VC_INDEX   (v)
      ) u_tracker (
         .clk     (clk),
         .arst_n  (arst_n),
         .send    (flitValid && (xbar_flit.fvcid == VC_ID_BITS'(v))),
         .tail    (flitTail),
         .head    (flitHead),
         .credit  (credit_valid && (credit_vcid == VC_ID_BITS'(v))),
         .alloc   (alloc_valid && (alloc_vcid == VC_ID_BITS'(v))),
         .count_r (credits_count_r[v]),
         .free_r  (vc_free_r[v])
      );
   end

`ifdef OB_OUTFLIT_REG_EN
   channel_t outflit_q;

   always_ff @(posedge clk) begin
      if (!arst_n) begin
         outflit_q <= '{ftype: I, fvcid: '0, data: '0};
      end else begin
         outflit_q <= xbar_flit;
      end
   end

   assign outflit = outflit_q;
`else
   assign outflit = xbar_flit;
`endif

endmodule

// File: tb/tb_output_block_vc.sv
// Directed bench for output_block_vc: credit counting, VC ownership FSM and reset.
// Inputs are held after each edge, so outflit matches the step's flit in either build.
`timescale 1ns/1ps
module tb_output_block_vc;
   import router_pkg::*;

   logic                                     clk = 1'b0;
   logic                                     arst_n;
   channel_t                                 xbar_flit;
   logic                                     credit_valid;
   logic [VC_ID_BITS-1:0]                    credit_vcid;
   logic                                     alloc_valid;
   logic [VC_ID_BITS-1:0]                    alloc_vcid;
   channel_t                                 outflit;
   logic [NUM_VCS-1:0][CREDIT_CTR_WIDTH-1:0] credits_count_r;
   logic [NUM_VCS-1:0]                       vc_free_r;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   output_block_vc #(
      .LOCAL_PORT (N)
   ) dut (
      .clk             (clk),
      .arst_n          (arst_n),
      .xbar_flit       (xbar_flit),
      .credit_valid    (credit_valid),
      .credit_vcid     (credit_vcid),
      .alloc_valid     (alloc_valid),
      .alloc_vcid      (alloc_vcid),
      .outflit         (outflit),
      .credits_count_r (credits_count_r),
      .vc_free_r       (vc_free_r)
   );

   function automatic channel_t makeFlit(input ftype_t t, input int vc, input int d);
      channel_t r;
      r.ftype = t;
      r.fvcid = VC_ID_BITS'(vc);
      r.data  = FLIT_DATA_WIDTH'(d);
      return r;
   endfunction

   task automatic compareVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, clock it in, and settle just past the edge.
   task automatic applyStimulus(input channel_t f, input logic cv, input int cid,
                                input logic av, input int aid);
      xbar_flit    = f;
      credit_valid = cv;
      credit_vcid  = VC_ID_BITS'(cid);
      alloc_valid  = av;
      alloc_vcid   = VC_ID_BITS'(aid);
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input channel_t expFlit, input int expC0,
                              input int expC1, input logic [1:0] expFree);
      compareVal({tag, ".outflit"}, 32'(outflit), 32'(expFlit));
      compareVal({tag, ".count0"}, 32'(credits_count_r[0]), 32'(expC0));
      compareVal({tag, ".count1"}, 32'(credits_count_r[1]), 32'(expC1));
      compareVal({tag, ".vcfree"}, 32'(vc_free_r), 32'(expFree));
   endtask

   initial begin
      channel_t idle;
      channel_t f;
      idle = makeFlit(I, 0, 0);

      arst_n = 1'b0;
      for (int i = 0; i < 3; i++) applyStimulus(idle, 1'b0, 0, 1'b0, 0);
      checkOutput("reset", idle, 4, 4, 2'b11);
      arst_n = 1'b1;

      // Packet H,B,B,T on VC1 with no credits returning.
      applyStimulus(idle, 1'b0, 0, 1'b1, 1);
      checkOutput("alloc1", idle, 4, 4, 2'b01);
      f = makeFlit(H, 1, 16'hA001);
      applyStimulus(f, 1'b0, 0, 1'b0, 0);
      checkOutput("v1_head", f, 4, 3, 2'b01);
      f = makeFlit(B, 1, 16'hA002);
      applyStimulus(f, 1'b0, 0, 1'b0, 0);
      checkOutput("v1_body1", f, 4, 2, 2'b01);
      f = makeFlit(B, 1, 16'hA003);
      applyStimulus(f, 1'b0, 0, 1'b0, 0);
      checkOutput("v1_body2", f, 4, 1, 2'b01);
      f = makeFlit(T, 1, 16'hA004);
      applyStimulus(f, 1'b0, 0, 1'b0, 0);
      checkOutput("v1_tail", f, 4, 0, 2'b01);

      // Credits refill VC1; it frees on the cycle the count shows full.
      applyStimulus(idle, 1'b1, 1, 1'b0, 0);
      checkOutput("v1_cred1", idle, 4, 1, 2'b01);
      applyStimulus(idle, 1'b1, 1, 1'b0, 0);
      checkOutput("v1_cred2", idle, 4, 2, 2'b01);
      applyStimulus(idle, 1'b1, 1, 1'b0, 0);
      checkOutput("v1_cred3", idle, 4, 3, 2'b01);
      applyStimulus(idle, 1'b1, 1, 1'b0, 0);
      checkOutput("v1_cred4", idle, 4, 4, 2'b11);

      // VC0 down to two credits, then a send and a credit together.
      applyStimulus(idle, 1'b0, 0, 1'b1, 0);
      checkOutput("alloc0_a", idle, 4, 4, 2'b10);
      f = makeFlit(H, 0, 16'hB001);
      applyStimulus(f, 1'b0, 0, 1'b0, 0);
      checkOutput("v0_head", f, 3, 4, 2'b10);
      f = makeFlit(B, 0, 16'hB002);
      applyStimulus(f, 1'b0, 0, 1'b0, 0);
      checkOutput("v0_body", f, 2, 4, 2'b10);
      f = makeFlit(B, 0, 16'hB003);
      applyStimulus(f, 1'b1, 0, 1'b0, 0);
      checkOutput("v0_send_and_credit", f, 2, 4, 2'b10);
      f = makeFlit(T, 0, 16'hB004);
      applyStimulus(f, 1'b0, 0, 1'b0, 0);
      checkOutput("v0_tail", f, 1, 4, 2'b10);
      applyStimulus(idle, 1'b1, 0, 1'b0, 0);
      checkOutput("v0_cred_a", idle, 2, 4, 2'b10);
      applyStimulus(idle, 1'b1, 0, 1'b0, 0);
      checkOutput("v0_cred_b", idle, 3, 4, 2'b10);
      applyStimulus(idle, 1'b1, 0, 1'b0, 0);
      checkOutput("v0_cred_c", idle, 4, 4, 2'b11);

      // Single-flit packet: HT goes straight to DRAIN.
      applyStimulus(idle, 1'b0, 0, 1'b1, 0);
      checkOutput("alloc0_b", idle, 4, 4, 2'b10);
      f = makeFlit(HT, 0, 16'hC001);
      applyStimulus(f, 1'b0, 0, 1'b0, 0);
      checkOutput("v0_headtail", f, 3, 4, 2'b10);
      applyStimulus(idle, 1'b0, 0, 1'b0, 0);
      checkOutput("v0_drain_hold", idle, 3, 4, 2'b10);
      applyStimulus(idle, 1'b1, 0, 1'b0, 0);
      checkOutput("v0_drain_done", idle, 4, 4, 2'b11);

      // Illegal re-allocation of a busy VC, then tail on VC0 alongside alloc on VC1.
      applyStimulus(idle, 1'b0, 0, 1'b1, 0);
      checkOutput("alloc0_c", idle, 4, 4, 2'b10);
      f = makeFlit(H, 0, 16'hD001);
      applyStimulus(f, 1'b0, 0, 1'b0, 0);
      checkOutput("v0_head2", f, 3, 4, 2'b10);
      applyStimulus(idle, 1'b0, 0, 1'b1, 0);
      checkOutput("alloc0_busy", idle, 3, 4, 2'b10);
      f = makeFlit(B, 0, 16'hD002);
      applyStimulus(f, 1'b0, 0, 1'b0, 0);
      checkOutput("v0_body2", f, 2, 4, 2'b10);
      f = makeFlit(T, 0, 16'hD003);
      applyStimulus(f, 1'b0, 0, 1'b1, 1);
      checkOutput("v0_tail_v1_alloc", f, 1, 4, 2'b00);
      f = makeFlit(H, 1, 16'hE001);
      applyStimulus(f, 1'b0, 0, 1'b0, 0);
      checkOutput("v1_head2", f, 1, 3, 2'b00);

      // Reset mid-packet discards everything at once.
      arst_n = 1'b0;
      applyStimulus(idle, 1'b0, 0, 1'b0, 0);
      checkOutput("reset_mid", idle, 4, 4, 2'b11);
      arst_n = 1'b1;
      applyStimulus(idle, 1'b0, 0, 1'b0, 0);
      checkOutput("post_reset", idle, 4, 4, 2'b11);

      // A credit on a full counter saturates.
      applyStimulus(idle, 1'b1, 1, 1'b0, 0);
      checkOutput("v1_overflow", idle, 4, 4, 2'b11);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
